// File: rtl/mux_skid_n.sv
// mux_skid_n: selects one of NUM_IN packed sources per upstream beat and
// buffers the result in a two-entry skid buffer (MAIN + SKID) with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset (highest priority)
//   flush      synchronous flush: drops all buffered beats and the beat offered this cycle
//   in_valid   upstream beat present
//   in_ready   block can accept a beat (decoded from state only)
//   sel        source index of the upstream beat
//   data_in    packed sources, source k at [k*WIDTH +: WIDTH]
//   out_valid  data_out holds a valid beat
//   out_ready  downstream accepts the beat
//   data_out   registered selected beat, zero when out_valid is low
//   sel_err    sticky: an out-of-range select was accepted (cleared by reset only)
module mux_skid_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_IN*WIDTH-1:0]   data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  main_r;
  logic [WIDTH-1:0]  skid_r;
  logic              sel_err_r;

  logic [WIDTH-1:0]  pick_val_s;
  logic              pick_ok_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              accept_s;
  logic              take_s;

  // Handshake flags are pure decodes of the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready_s  = (state_r != ST_FULL);
  assign out_valid_s = (state_r != ST_EMPTY);
  assign accept_s    = in_valid && in_ready_s;
  assign take_s      = out_valid_s && out_ready;

  // Source multiplexer: a select with no matching source yields zero and
  // reports itself as out of range.
  always_comb begin
    pick_val_s = '0;
    pick_ok_s  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_ok_s  = 1'b1;
        pick_val_s = data_in[k*WIDTH +: WIDTH];
      end else begin
        pick_ok_s  = pick_ok_s;
      end
    end
  end

  // Buffer state machine. MAIN is kept at zero whenever the buffer is empty
  // so data_out can be driven straight from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      main_r    <= '0;
      skid_r    <= '0;
      sel_err_r <= 1'b0;
    end else if (flush) begin
      // Offered beat is dropped; sel_err keeps its value.
      state_r <= ST_EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else begin
      if (accept_s && !pick_ok_s) begin
        sel_err_r <= 1'b1;
      end
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r <= ST_ONE;
            main_r  <= pick_val_s;
          end
        end
        ST_ONE: begin
          if (accept_s && take_s) begin
            main_r <= pick_val_s;
          end else if (accept_s) begin
            state_r <= ST_FULL;
            skid_r  <= pick_val_s;
          end else if (take_s) begin
            state_r <= ST_EMPTY;
            main_r  <= '0;
          end
        end
        ST_FULL: begin
          if (take_s) begin
            state_r <= ST_ONE;
            main_r  <= skid_r;
            skid_r  <= '0;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          main_r  <= '0;
          skid_r  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign data_out  = main_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_skid_n.sv
// Testbench for mux_skid_n: two instances (NUM_IN=4 and NUM_IN=3) share the
// stimulus; a queue model per instance is checked every cycle, and directed
// scenarios also pin outputs against hand-computed literals.
module tb_mux_skid_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  sel;
  logic [19:0] data_in;

  logic        in_ready0, out_valid0, sel_err0;
  logic [4:0]  data_out0;
  logic        in_ready1, out_valid1, sel_err1;
  logic [4:0]  data_out1;

  int checks = 0;
  int failures = 0;

  int q0[$];
  int q1[$];
  bit err0 = 1'b0;
  bit err1 = 1'b0;
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  mux_skid_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready0), .sel(sel), .data_in(data_in),
    .out_valid(out_valid0), .out_ready(out_ready), .data_out(data_out0),
    .sel_err(sel_err0)
  );

  mux_skid_n #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready1), .sel(sel), .data_in(data_in[14:0]),
    .out_valid(out_valid1), .out_ready(out_ready), .data_out(data_out1),
    .sel_err(sel_err1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each instance is a FIFO of capacity two.
  always @(posedge clk) begin
    int s;
    bit acc;
    s = int'(sel);
    if (reset) begin
      q0.delete();
      q1.delete();
      err0 = 1'b0;
      err1 = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        acc = in_valid && (q0.size() < 2);
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (acc) begin
          q0.push_back((s < 4) ? int'(data_in[s*5 +: 5]) : 0);
          if (s >= 4) err0 = 1'b1;
        end
        acc = in_valid && (q1.size() < 2);
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (acc) begin
          q1.push_back((s < 3) ? int'(data_in[s*5 +: 5]) : 0);
          if (s >= 3) err1 = 1'b1;
        end
      end
    end
  end

  // Compare process: outputs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("in_ready0",  32'(in_ready0),  32'(q0.size() < 2));
      chk("out_valid0", 32'(out_valid0), 32'(q0.size() > 0));
      chk("data_out0",  32'(data_out0),  (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
      chk("sel_err0",   32'(sel_err0),   32'(err0));
      chk("in_ready1",  32'(in_ready1),  32'(q1.size() < 2));
      chk("out_valid1", 32'(out_valid1), 32'(q1.size() > 0));
      chk("data_out1",  32'(data_out1),  (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
      chk("sel_err1",   32'(sel_err1),   32'(err1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
    data_in = {5'd19, 5'd11, 5'd7, 5'd3};
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_in_ready",  32'(in_ready0),  32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_data_out",  32'(data_out0),  32'd0);
    chk("rst_sel_err",   32'(sel_err1),   32'd0);

    // Streaming, one beat per cycle
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    cyc();
    chk("stream_11", 32'(data_out0), 32'd11);
    chk("stream_ov", 32'(out_valid0), 32'd1);
    sel = 2'd1;
    cyc();
    chk("stream_7", 32'(data_out0), 32'd7);
    chk("stream_ir", 32'(in_ready0), 32'd1);
    sel = 2'd0;
    cyc();
    chk("stream_3", 32'(data_out0), 32'd3);
    in_valid = 1'b0;
    cyc();
    chk("stream_empty", 32'(out_valid0), 32'd0);
    chk("stream_err1", 32'(sel_err1), 32'd0);

    // Backpressure into FULL, then drain
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    cyc();
    sel = 2'd3;
    cyc();
    in_valid = 1'b0;
    chk("bp_in_ready", 32'(in_ready0), 32'd0);
    chk("bp_hold3", 32'(data_out0), 32'd3);
    chk("oor_err1", 32'(sel_err1), 32'd1);
    chk("oor_err0", 32'(sel_err0), 32'd0);
    cyc();
    chk("bp_hold3b", 32'(data_out0), 32'd3);
    out_ready = 1'b1;
    cyc();
    chk("bp_19", 32'(data_out0), 32'd19);
    chk("oor_zero", 32'(data_out1), 32'd0);
    chk("oor_ov", 32'(out_valid1), 32'd1);
    cyc();
    chk("bp_empty_ov", 32'(out_valid0), 32'd0);
    chk("bp_empty_do", 32'(data_out0), 32'd0);

    // Flush while FULL with a beat offered
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    cyc();
    sel = 2'd2;
    cyc();
    flush = 1'b1; sel = 2'd0;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_ov", 32'(out_valid0), 32'd0);
    chk("fl_ir", 32'(in_ready0), 32'd1);
    chk("fl_do", 32'(data_out0), 32'd0);
    chk("fl_err1_sticky", 32'(sel_err1), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("fl_no_beat", 32'(out_valid0), 32'd0);

    // Reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    cyc();
    sel = 2'd2;
    cyc();
    reset = 1'b1; in_valid = 1'b0;
    cyc();
    reset = 1'b0;
    chk("rf_ov", 32'(out_valid0), 32'd0);
    chk("rf_do", 32'(data_out0), 32'd0);
    chk("rf_ir", 32'(in_ready0), 32'd1);
    chk("rf_err1", 32'(sel_err1), 32'd0);
    in_valid = 1'b1; sel = 2'd2; out_ready = 1'b1;
    cyc();
    chk("rf_first", 32'(data_out0), 32'd11);
    chk("rf_first_ov", 32'(out_valid0), 32'd1);
    in_valid = 1'b0;
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      sel       = 2'($urandom_range(3, 0));
      data_in   = 20'($urandom);
      flush     = ($urandom_range(31, 0) == 0);
      reset     = ($urandom_range(199, 0) == 0);
      cyc();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
